// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path.
// Holds the opcode constants, the ALU operation classes, the controller state enum,
// the datapath mux encodings and the supported branch funct3 codes.
package riscv_ctrl_pkg;

  // Major opcodes (IR[6:0])
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  // ALU operation classes; SPECIAL defers to the funct3/funct7 decoder
  localparam logic [2:0] AluAdd     = 3'b000;
  localparam logic [2:0] AluSub     = 3'b001;
  localparam logic [2:0] AluShl     = 3'b011;
  localparam logic [2:0] AluCmp     = 3'b100;
  localparam logic [2:0] AluSpecial = 3'b111;

  // ALU operand A select
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Immediate format select
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // Result bus select
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // Supported branch funct3 codes
  localparam logic [2:0] F3Beq = 3'b000;
  localparam logic [2:0] F3Bne = 3'b001;
  localparam logic [2:0] F3Blt = 3'b100;
  localparam logic [2:0] F3Bge = 3'b101;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StExecI    = 4'd8,
    StAluWb    = 4'd9,
    StBranch   = 4'd10,
    StJal      = 4'd11,
    StLui      = 4'd12,
    StTrap     = 4'd13
  } state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from the ALU flags.
// Ports:
//   funct3 in  3  branch type (IR[14:12])
//   zero   in  1  ALU result == 0
//   lt     in  1  ALU signed less-than
//   taken  out 1  branch condition holds
//   valid  out 1  funct3 is a supported branch (beq/bne/blt/bge)
module branch_cond
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken,
  output logic       valid
);

  always_comb begin
    taken = 1'b0;
    valid = 1'b1;
    case (funct3)
      F3Beq:   taken = zero;
      F3Bne:   taken = !zero;
      F3Blt:   taken = lt;
      F3Bge:   taken = !lt;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32 core.
// Sequences the shared datapath through fetch/decode/execute/memory/writeback.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct3      instruction fields from IR (valid from DECODE on)
//   zero, lt            ALU flags used by branches
//   mem_ready           memory handshake, only meaningful while mem_req=1
//   mem_req, mem_write  memory request / store qualifier
//   adr_src             memory address select (PC / ALUOut)
//   ir_write, pc_write, reg_write   architectural write enables
//   alu_src_a, alu_src_b, imm_src, result_src, alu_op   datapath selects
//   instr_done          one-cycle pulse in the final cycle of each instruction
//   illegal_instr       sticky illegal-instruction flag
//   state               current FSM state for debug
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   illegal_q;
  logic   br_taken, br_valid;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .taken  (br_taken),
    .valid  (br_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky illegal flag; set on entry so it is visible throughout TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (state_d == StTrap) begin
      illegal_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StLui:      state_d = StAluWb;
      StJal:      state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = br_valid ? StFetch : StTrap;
      StTrap:     state_d = StTrap;
      default:    state_d = StIdle;
    endcase
  end

  // Output decode; Moore except the handshake/flag-qualified enables
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    imm_src    = ImmI;
    result_src = ResAluOut;
    alu_op     = AluAdd;
    instr_done = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        imm_src   = (opcode == OpJal) ? ImmJ : ImmB;
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        imm_src   = (opcode == OpStore) ? ImmS : ImmI;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = ResReadData;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StMemWrite: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        adr_src    = 1'b1;
        instr_done = mem_ready;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBRs2;
        alu_op    = AluSpecial;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        imm_src   = ImmI;
        alu_op    = AluSpecial;
      end
      StLui: begin
        alu_src_a = SrcAZero;
        alu_src_b = SrcBImm;
        imm_src   = ImmU;
      end
      StJal: begin
        // PC <= target held in ALUOut from DECODE; ALU forms oldPC+4 for rd
        alu_src_a  = SrcAOldPc;
        alu_src_b  = SrcBFour;
        result_src = ResAluOut;
        pc_write   = 1'b1;
      end
      StAluWb: begin
        result_src = ResAluOut;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alu_src_a  = SrcARs1;
        alu_src_b  = SrcBRs2;
        result_src = ResAluOut;
        if (br_valid) begin
          alu_op     = funct3[2] ? AluCmp : AluSub;
          pc_write   = br_taken;
          instr_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign illegal_instr = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;

  logic       clk, rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero, lt, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src, alu_op;
  logic       instr_done, illegal_instr;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMREAD = 4'd4, S_MEMWB = 4'd5, S_MEMWRITE = 4'd6,
                         S_EXECI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
                         S_TRAP = 4'd13;

  multicycle_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .zero          (zero),
    .lt            (lt),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .result_src    (result_src),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] ctrl;
  assign ctrl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, alu_src_a,
                 alu_src_b, imm_src, result_src, alu_op, instr_done, illegal_instr};

  function automatic logic [19:0] cw(input logic req, input logic wr, input logic asrc,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [1:0] res,
                                     input logic [2:0] op, input logic done,
                                     input logic ill);
    return {req, wr, asrc, irw, pcw, rgw, a, b, imm, res, op, done, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge: apply mem_ready, check mid-cycle, advance one clock
  task automatic run_state(input string tag, input logic rdy, input logic [3:0] st,
                           input logic [19:0] exp);
    mem_ready = rdy;
    #2;
    check_eq({tag, " state"}, {28'd0, state}, {28'd0, st});
    check_eq({tag, " ctrl"}, {12'd0, ctrl}, {12'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [19:0] w_fetch, w_dec_b, w_dec_j, w_execi, w_aluwb, w_madr_l, w_madr_s;
  logic [19:0] w_mread, w_memwb, w_jal, w_trap;

  initial begin
    w_fetch  = cw(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0);
    w_dec_b  = cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b010, 2'b00, 3'b000, 0, 0);
    w_dec_j  = cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b011, 2'b00, 3'b000, 0, 0);
    w_execi  = cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b111, 0, 0);
    w_aluwb  = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0);
    w_madr_l = cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0, 0);
    w_madr_s = cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b001, 2'b00, 3'b000, 0, 0);
    w_mread  = cw(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0);
    w_memwb  = cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 1, 0);
    w_jal    = cw(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, 0, 0);
    w_trap   = 20'h00001;

    rst_n = 1'b0; opcode = 7'h00; funct3 = 3'b000; zero = 1'b0; lt = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset state", {28'd0, state}, 32'd0);
    check_eq("reset ctrl", {12'd0, ctrl}, 32'd0);
    rst_n = 1'b1;

    // addi x1, x0, 5 : instr_done in cycle 5 after reset
    opcode = 7'b0010011;
    run_state("addi idle", 1, S_IDLE, 20'd0);
    run_state("addi fetch", 1, S_FETCH, w_fetch);
    run_state("addi decode", 1, S_DECODE, w_dec_b);
    run_state("addi execi", 1, S_EXECI, w_execi);
    run_state("addi aluwb", 1, S_ALUWB, w_aluwb);

    // lw with three wait cycles in MEMREAD: 8 cycles from FETCH
    opcode = 7'b0000011;
    run_state("lw fetch", 1, S_FETCH, w_fetch);
    run_state("lw decode", 1, S_DECODE, w_dec_b);
    run_state("lw memadr", 1, S_MEMADR, w_madr_l);
    for (int i = 0; i < 3; i++) run_state("lw wait", 0, S_MEMREAD, w_mread);
    run_state("lw ready", 1, S_MEMREAD, w_mread);
    run_state("lw memwb", 1, S_MEMWB, w_memwb);

    // beq taken / not taken, bge taken
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    run_state("beq1 fetch", 1, S_FETCH, w_fetch);
    run_state("beq1 decode", 1, S_DECODE, w_dec_b);
    run_state("beq1 branch", 1, S_BRANCH,
              cw(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 1, 0));
    zero = 1'b0;
    run_state("beq0 fetch", 1, S_FETCH, w_fetch);
    run_state("beq0 decode", 1, S_DECODE, w_dec_b);
    run_state("beq0 branch", 1, S_BRANCH,
              cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 1, 0));
    funct3 = 3'b101; lt = 1'b0;
    run_state("bge fetch", 1, S_FETCH, w_fetch);
    run_state("bge decode", 1, S_DECODE, w_dec_b);
    run_state("bge branch", 1, S_BRANCH,
              cw(0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b100, 1, 0));

    // jal
    opcode = 7'b1101111;
    run_state("jal fetch", 1, S_FETCH, w_fetch);
    run_state("jal decode", 1, S_DECODE, w_dec_j);
    run_state("jal jal", 1, S_JAL, w_jal);
    run_state("jal aluwb", 1, S_ALUWB, w_aluwb);

    // sw, one fetch wait, completes on the first store request
    opcode = 7'b0100011;
    run_state("sw fetch wait", 0, S_FETCH,
              cw(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0));
    run_state("sw fetch", 1, S_FETCH, w_fetch);
    run_state("sw decode", 1, S_DECODE, w_dec_b);
    run_state("sw memadr", 1, S_MEMADR, w_madr_s);
    run_state("sw memwrite", 1, S_MEMWRITE,
              cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1, 0));

    // sw interrupted by reset during a wait
    run_state("sw2 fetch", 1, S_FETCH, w_fetch);
    run_state("sw2 decode", 1, S_DECODE, w_dec_b);
    run_state("sw2 memadr", 1, S_MEMADR, w_madr_s);
    run_state("sw2 wait", 0, S_MEMWRITE,
              cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0));
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async rst mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("async rst mem_write", {31'd0, mem_write}, 32'd0);
    check_eq("async rst state", {28'd0, state}, {28'd0, S_IDLE});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_state("post rst idle", 1, S_IDLE, 20'd0);
    run_state("post rst fetch", 1, S_FETCH, w_fetch);

    // Illegal opcode 0x7F: TRAP held with all enables low
    opcode = 7'h7F;
    run_state("trap decode", 1, S_DECODE, w_dec_b);
    for (int i = 0; i < 10; i++) run_state("trap hold", i[0], S_TRAP, w_trap);
    rst_n = 1'b0;
    #1;
    check_eq("trap cleared ill", {31'd0, illegal_instr}, 32'd0);
    check_eq("trap cleared state", {28'd0, state}, {28'd0, S_IDLE});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // bltu is unsupported: no PC write, no instr_done, then TRAP
    opcode = 7'b1100011; funct3 = 3'b110; zero = 1'b1; lt = 1'b1;
    run_state("bltu idle", 1, S_IDLE, 20'd0);
    run_state("bltu fetch", 1, S_FETCH, w_fetch);
    run_state("bltu decode", 1, S_DECODE, w_dec_b);
    run_state("bltu branch", 1, S_BRANCH,
              cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0));
    run_state("bltu trap", 1, S_TRAP, w_trap);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
